// File: rtl/bf8_bus_pkg.sv
// Shared BrainForge8 bus definitions: arbiter state encoding, owner-index
// width helper and the default arbiter timing constants.
package bf8_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT     = 255;
    localparam int DEFAULT_HANDOFF_GAP = 1;

    // Width of a master index; never narrower than one bit.
    function automatic int ow_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bf8_rr_picker.sv
// Combinational round-robin search: first set bit of req, scanning upward
// from last+1 and wrapping around, so last itself is checked last.
module bf8_rr_picker
    import bf8_bus_pkg::*;
#(
    parameter int N = 4,
    parameter int W = ow_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] idx
);

    localparam int unsigned NU = N;

    // Scan all N positions starting one above last; keep the first hit.
    always_comb begin
        int unsigned k;
        valid = 1'b0;
        idx   = '0;
        k     = 0;
        for (int unsigned i = 1; i <= NU; i++) begin
            k = (32'(last) + i) % NU;
            if (!valid && req[W'(k)]) begin
                valid = 1'b1;
                idx   = W'(k);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Board-level BR/BA bus arbiter: round-robin grant of a single BA, a
// guaranteed all-low gap between tenures, and a tenure watchdog that
// revokes and penalises a master that never releases.
module bus_arbiter
    import bf8_bus_pkg::*;
#(
    parameter int N_MASTERS   = 4,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int HANDOFF_GAP = DEFAULT_HANDOFF_GAP,
    localparam int OW         = ow_width(N_MASTERS)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] BR,
    output logic [N_MASTERS-1:0] BA,
    output logic [OW-1:0]        OWNER,
    output logic                 BUSY,
    output logic                 TOUT,
    output logic [OW-1:0]        TOUT_ID
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);
    localparam logic [3:0] HG  = 4'(HANDOFF_GAP);

    logic [N_MASTERS-1:0] br_meta, br_sync;

    arb_state_t           state_q, state_n;
    logic [N_MASTERS-1:0] ba_q, ba_n;
    logic [OW-1:0]        owner_q, owner_n;
    logic [OW-1:0]        last_q, last_n;
    logic [7:0]           tenure_q, tenure_n;
    logic [3:0]           gap_q, gap_n;
    logic                 tout_q, tout_n;
    logic [OW-1:0]        tout_id_q, tout_id_n;
    logic [N_MASTERS-1:0] pen_q, pen_n;

    logic                 pick_valid;
    logic [OW-1:0]        pick_idx;

    bf8_rr_picker #(
        .N (N_MASTERS),
        .W (OW)
    ) u_picker (
        .req   (br_sync & ~pen_q),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Double-flop synchroniser for requests arriving from other clock domains.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            br_meta <= '0;
            br_sync <= '0;
        end else begin
            br_meta <= BR;
            br_sync <= br_meta;
        end
    end

    // Arbiter state register; reset drops BA without waiting for an edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            ba_q      <= '0;
            owner_q   <= '0;
            last_q    <= OW'(N_MASTERS - 1);
            tenure_q  <= '0;
            gap_q     <= '0;
            tout_q    <= 1'b0;
            tout_id_q <= '0;
            pen_q     <= '0;
        end else begin
            state_q   <= state_n;
            ba_q      <= ba_n;
            owner_q   <= owner_n;
            last_q    <= last_n;
            tenure_q  <= tenure_n;
            gap_q     <= gap_n;
            tout_q    <= tout_n;
            tout_id_q <= tout_id_n;
            pen_q     <= pen_n;
        end
    end

    // Next-state logic: grant in IDLE, release/watchdog in GRANT, count down in GAP.
    always_comb begin
        state_n   = state_q;
        ba_n      = ba_q;
        owner_n   = owner_q;
        last_n    = last_q;
        tenure_n  = tenure_q;
        gap_n     = gap_q;
        tout_n    = 1'b0;
        tout_id_n = tout_id_q;
        // A penalty is forgiven on any edge where that master's request is low.
        pen_n     = pen_q & br_sync;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    ba_n           = '0;
                    ba_n[pick_idx] = 1'b1;
                    owner_n        = pick_idx;
                    tenure_n       = 8'd1;
                    state_n        = GRANT;
                end
            end
            GRANT: begin
                // Release takes priority over a watchdog expiry on the same edge.
                if (!br_sync[owner_q]) begin
                    ba_n    = '0;
                    last_n  = owner_q;
                    gap_n   = HG;
                    state_n = (HG == 4'd0) ? IDLE : GAP;
                end else if ((TIMEOUT != 0) && (tenure_q == TMO)) begin
                    ba_n           = '0;
                    tout_n         = 1'b1;
                    tout_id_n      = owner_q;
                    pen_n[owner_q] = 1'b1;
                    last_n         = owner_q;
                    gap_n          = HG;
                    state_n        = (HG == 4'd0) ? IDLE : GAP;
                end else if (tenure_q != 8'hFF) begin
                    tenure_n = tenure_q + 8'd1;
                end
            end
            GAP: begin
                if (gap_q <= 4'd1) begin
                    gap_n   = '0;
                    state_n = IDLE;
                end else begin
                    gap_n = gap_q - 4'd1;
                end
            end
            default: begin
                ba_n    = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign BA      = ba_q;
    assign BUSY    = |ba_q;
    assign OWNER   = owner_q;
    assign TOUT    = tout_q;
    assign TOUT_ID = tout_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (4 masters, TIMEOUT=8,
// HANDOFF_GAP=1). Pin-to-grant latency is 3 edges: two sync flops plus one.
module tb_bus_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] BR;
    logic [3:0] BA;
    logic [1:0] OWNER;
    logic       BUSY;
    logic       TOUT;
    logic [1:0] TOUT_ID;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(
        .N_MASTERS   (4),
        .TIMEOUT     (8),
        .HANDOFF_GAP (1)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .BR      (BR),
        .BA      (BA),
        .OWNER   (OWNER),
        .BUSY    (BUSY),
        .TOUT    (TOUT),
        .TOUT_ID (TOUT_ID)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    int seq [6];
    int n_grants;
    int held;
    logic [3:0] prev_ba;

    initial begin
        RST = 1'b1;
        BR  = 4'b0000;
        #2 RST = 1'b0;
        tick(3);

        // Reset state
        check("rst_ba",      BA,      0);
        check("rst_busy",    BUSY,    0);
        check("rst_tout",    TOUT,    0);
        check("rst_owner",   OWNER,   0);
        check("rst_tout_id", TOUT_ID, 0);
        RST = 1'b1;
        tick(2);

        // 1: single master, one-cycle grant latency after sync, release clears BA
        BR = 4'b0001;
        tick(2);
        check("t1_no_grant_yet", BA, 4'b0000);
        tick(1);
        check("t1_ba",    BA,    4'b0001);
        check("t1_owner", OWNER, 0);
        check("t1_busy",  BUSY,  1);
        tick(1);
        BR = 4'b0000;
        tick(2);
        check("t1_still_held", BA, 4'b0001);
        tick(1);
        check("t1_release_ba",   BA,   4'b0000);
        check("t1_release_busy", BUSY, 0);
        tick(4);

        // 2: two simultaneous requests, 2-cycle dead gap, then master 1
        do_reset();
        BR = 4'b0011;
        tick(3);
        check("t2_first_ba", BA, 4'b0001);
        BR = 4'b0010;
        tick(2);
        check("t2_m0_held", BA, 4'b0001);
        tick(1);
        check("t2_gap1", BA, 4'b0000);
        tick(1);
        check("t2_gap2",       BA,    4'b0000);
        check("t2_owner_hold", OWNER, 0);
        tick(1);
        check("t2_second_ba",    BA,    4'b0010);
        check("t2_second_owner", OWNER, 1);
        BR = 4'b0000;
        tick(8);

        // 3: all masters contend; each releases after 3 cycles and re-requests
        do_reset();
        for (int i = 0; i < 6; i++) seq[i] = -1;
        n_grants = 0;
        held     = 0;
        prev_ba  = 4'b0000;
        BR       = 4'b1111;
        for (int c = 0; c < 300 && n_grants < 6; c++) begin
            tick(1);
            BR = 4'b1111;
            if (BA != 4'b0000) begin
                if (prev_ba == 4'b0000) begin
                    seq[n_grants] = int'(OWNER);
                    n_grants++;
                    held = 0;
                end
                held++;
                if (held == 3) BR = ~BA;
            end
            prev_ba = BA;
        end
        check("t3_grant_count", n_grants, 6);
        check("t3_g0", seq[0], 0);
        check("t3_g1", seq[1], 1);
        check("t3_g2", seq[2], 2);
        check("t3_g3", seq[3], 3);
        check("t3_g4", seq[4], 0);
        check("t3_g5", seq[5], 1);
        BR = 4'b0000;
        tick(8);
        check("t3_idle", BA, 4'b0000);

        // 4: watchdog revokes master 2, master 1 served, master 2 penalised
        BR = 4'b0100;
        tick(3);
        check("t4_m2_ba",    BA,    4'b0100);
        check("t4_m2_owner", OWNER, 2);
        BR = 4'b0110;
        tick(7);
        check("t4_ba_cycle8", BA,   4'b0100);
        check("t4_no_tout",   TOUT, 0);
        tick(1);
        check("t4_revoke_ba", BA,      4'b0000);
        check("t4_tout",      TOUT,    1);
        check("t4_tout_id",   TOUT_ID, 2);
        tick(1);
        check("t4_tout_pulse", TOUT, 0);
        check("t4_gap_ba",     BA,   4'b0000);
        tick(1);
        check("t4_m1_ba",    BA,    4'b0010);
        check("t4_m1_owner", OWNER, 1);
        BR = 4'b0100;
        tick(7);
        check("t4_m2_penalised", BA, 4'b0000);
        BR = 4'b0000;
        tick(1);
        BR = 4'b0100;
        tick(2);
        check("t4_m2_still_out", BA, 4'b0000);
        tick(1);
        check("t4_m2_regrant", BA,      4'b0100);
        check("t4_tout_id_kept", TOUT_ID, 2);
        BR = 4'b0000;
        tick(8);

        // 5: release lands on the edge where tenure reaches TIMEOUT
        BR = 4'b0001;
        tick(3);
        check("t5_m0_ba", BA, 4'b0001);
        tick(5);
        BR = 4'b0000;
        tick(2);
        check("t5_held_cycle8", BA, 4'b0001);
        tick(1);
        check("t5_release_ba", BA,   4'b0000);
        check("t5_no_tout",    TOUT, 0);
        tick(1);
        check("t5_no_tout_next", TOUT,    0);
        check("t5_tout_id_kept", TOUT_ID, 2);
        tick(6);

        // 6: async reset mid-tenure, away from any clock edge
        BR = 4'b1111;
        tick(3);
        check("t6_pre_busy",  BUSY,  1);
        check("t6_pre_owner", OWNER, 1);
        #2 RST = 1'b0;
        #1;
        check("t6_async_ba",   BA,    4'b0000);
        check("t6_async_busy", BUSY,  0);
        check("t6_async_own",  OWNER, 0);
        RST = 1'b1;
        tick(2);
        check("t6_sync_wait", BA, 4'b0000);
        tick(1);
        check("t6_after_ba", BA, 4'b0001);
        BR = 4'b0000;
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
